// File: rtl/baud_ctrl_pkg.sv
// baud_ctrl_pkg: shared definitions for the UART baud configuration sequencer.
//   - baud_state_e   : controller states (RUN, DRAIN, LOAD)
//   - BAUD_WIDTH     : default width of the modulo path
//   - MOD_*          : modulo values for standard rates at a 50 MHz clk_i
//   - DEFAULT_MODULO : modulo loaded at reset (115200 baud)
// The baud period is 2*(M+1) clk_i cycles, so M = clk/(2*rate) - 1.
package baud_ctrl_pkg;

  localparam int BAUD_WIDTH = 32;
  localparam int unsigned SYS_CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } baud_state_e;

  function automatic logic [BAUD_WIDTH-1:0] baud_modulo(input int unsigned clk_hz,
                                                       input int unsigned rate);
    return BAUD_WIDTH'(clk_hz / (2 * rate) - 1);
  endfunction

  localparam logic [BAUD_WIDTH-1:0] MOD_9600   = baud_modulo(SYS_CLK_HZ, 9600);   // 2603
  localparam logic [BAUD_WIDTH-1:0] MOD_19200  = baud_modulo(SYS_CLK_HZ, 19200);  // 1301
  localparam logic [BAUD_WIDTH-1:0] MOD_115200 = baud_modulo(SYS_CLK_HZ, 115200); // 216

  localparam logic [BAUD_WIDTH-1:0] DEFAULT_MODULO = MOD_115200;
  localparam logic [BAUD_WIDTH-1:0] MIN_MODULO     = BAUD_WIDTH'(4);
  localparam logic [BAUD_WIDTH-1:0] DRAIN_TIMEOUT  = BAUD_WIDTH'(65535);

endpackage

// File: rtl/baud_edge_det.sv
// baud_edge_det: registered rising-edge detector for the generator's baud_clk.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : synchronous clear of the sample history and the tick
//   en_i         : allows a detected edge to become a tick (sampling never stops)
//   din_i        : toggling baud clock from the generator
//   tick_o       : one-cycle pulse, registered, the cycle after din_i is seen rising
module baud_edge_det
  import baud_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic din_i,
  output logic tick_o
);

  logic prev;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      prev   <= 1'b0;
      tick_o <= 1'b0;
    end else begin
      prev   <= din_i;
      tick_o <= en_i & din_i & ~prev;
    end
  end

endmodule

// File: rtl/baud_ctrl.sv
// baud_ctrl: configuration sequencer for the UART baud generator.
// Accepts modulo updates over valid/ready, holds TX/RX off at frame boundaries,
// reloads the generator under a one-cycle reset and turns baud_clk into a tick.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   cfg_modulo_i/valid/ready: modulo update handshake
//   cfg_err_o               : pulse, request below MIN_MODULO rejected
//   cfg_timeout_o           : pulse, drain gave up waiting on busy engines
//   tx_busy_i, rx_busy_i    : engines are mid-frame
//   hold_o                  : engines must not start a new frame
//   baud_clk_i              : toggling generator output
//   baud_modulo_o           : modulo driven to the generator
//   baud_rst_n_o            : generator reset, active-low
//   baud_tick_o             : one-cycle enable per baud_clk_i rising edge
// Optional: define BAUD_DRAIN_TIMEOUT_EN to force a load after DRAIN_TIMEOUT
// drain cycles; otherwise DRAIN waits indefinitely and cfg_timeout_o is 0.
// All outputs are registered from the next state, so each reflects the state
// of the cycle it is visible in.
module baud_ctrl #(
  parameter int                    BAUD_WIDTH     = baud_ctrl_pkg::BAUD_WIDTH,
  parameter logic [BAUD_WIDTH-1:0] DEFAULT_MODULO = BAUD_WIDTH'(baud_ctrl_pkg::DEFAULT_MODULO),
  parameter logic [BAUD_WIDTH-1:0] MIN_MODULO     = BAUD_WIDTH'(baud_ctrl_pkg::MIN_MODULO),
  parameter logic [BAUD_WIDTH-1:0] DRAIN_TIMEOUT  = BAUD_WIDTH'(baud_ctrl_pkg::DRAIN_TIMEOUT)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [BAUD_WIDTH-1:0] cfg_modulo_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  output logic                  cfg_err_o,
  output logic                  cfg_timeout_o,
  input  logic                  tx_busy_i,
  input  logic                  rx_busy_i,
  output logic                  hold_o,
  input  logic                  baud_clk_i,
  output logic [BAUD_WIDTH-1:0] baud_modulo_o,
  output logic                  baud_rst_n_o,
  output logic                  baud_tick_o
);

  import baud_ctrl_pkg::*;

  baud_state_e           state, state_nxt;
  logic [BAUD_WIDTH-1:0] pending;
  logic                  pend_ld;
  logic                  err_nxt;

`ifdef BAUD_DRAIN_TIMEOUT_EN
  logic [BAUD_WIDTH-1:0] drain_cnt;
  logic                  tout_nxt;
`endif

  always_comb begin
    state_nxt = state;
    pend_ld   = 1'b0;
    err_nxt   = 1'b0;
`ifdef BAUD_DRAIN_TIMEOUT_EN
    tout_nxt  = 1'b0;
`endif
    case (state)
      ST_RUN: begin
        if (cfg_valid_i && cfg_ready_o) begin
          if (cfg_modulo_i < MIN_MODULO) begin
            err_nxt = 1'b1;
          end else if (cfg_modulo_i != baud_modulo_o) begin
            // Same-value requests complete here without disturbing the generator.
            pend_ld   = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!tx_busy_i && !rx_busy_i) begin
          state_nxt = ST_LOAD;
`ifdef BAUD_DRAIN_TIMEOUT_EN
        end else if (drain_cnt + BAUD_WIDTH'(1) == DRAIN_TIMEOUT) begin
          // drain_cnt counts completed drain cycles; this is the last allowed one.
          state_nxt = ST_LOAD;
          tout_nxt  = 1'b1;
`endif
        end
      end
      ST_LOAD:  state_nxt = ST_RUN;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_LOAD;
      pending       <= DEFAULT_MODULO;
      baud_modulo_o <= DEFAULT_MODULO;
      baud_rst_n_o  <= 1'b0;
      hold_o        <= 1'b1;
      cfg_ready_o   <= 1'b0;
      cfg_err_o     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cfg_ready_o  <= (state_nxt == ST_RUN);
      hold_o       <= (state_nxt != ST_RUN);
      baud_rst_n_o <= (state_nxt != ST_LOAD);
      cfg_err_o    <= err_nxt;
      if (pend_ld) pending <= cfg_modulo_i;
      // Modulo changes on LOAD entry so it is stable while the generator is in reset.
      if (state == ST_DRAIN && state_nxt == ST_LOAD) baud_modulo_o <= pending;
    end
  end

`ifdef BAUD_DRAIN_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drain_cnt     <= '0;
      cfg_timeout_o <= 1'b0;
    end else begin
      cfg_timeout_o <= tout_nxt;
      // Held at zero outside DRAIN, so it reads 0 on the first drain cycle.
      if (state != ST_DRAIN) drain_cnt <= '0;
      else                   drain_cnt <= drain_cnt + BAUD_WIDTH'(1);
    end
  end
`else
  logic unused_drain_timeout;
  assign unused_drain_timeout = ^DRAIN_TIMEOUT;
  assign cfg_timeout_o        = 1'b0;
`endif

  // Edge history is wiped in LOAD (generator is being reset); ticks only
  // surface in cycles whose state is RUN.
  baud_edge_det u_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state == ST_LOAD),
    .en_i   (state_nxt == ST_RUN),
    .din_i  (baud_clk_i),
    .tick_o (baud_tick_o)
  );

endmodule

// File: tb/tb_baud_ctrl.sv
// tb_baud_ctrl: self-checking bench for baud_ctrl. A simple baud generator
// model drives baud_clk_i; a reference model predicts every output each cycle,
// with ticks computed arithmetically from the last generator release.
module tb_baud_ctrl;

  localparam int          W    = 32;
  localparam logic [W-1:0] DEF  = 32'd216;
  localparam logic [W-1:0] MINM = 32'd4;
  localparam int          TOUT = 20;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [W-1:0] cfg_modulo_i = '0;
  logic         cfg_valid_i = 1'b0;
  logic         cfg_ready_o, cfg_err_o, cfg_timeout_o;
  logic         tx_busy_i = 1'b0, rx_busy_i = 1'b0;
  logic         hold_o;
  logic         baud_clk_i = 1'b0;
  logic [W-1:0] baud_modulo_o;
  logic         baud_rst_n_o, baud_tick_o;

  always #5 clk_i = ~clk_i;

  baud_ctrl #(
    .BAUD_WIDTH(W), .DEFAULT_MODULO(DEF), .MIN_MODULO(MINM), .DRAIN_TIMEOUT(32'(TOUT))
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_modulo_i(cfg_modulo_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_err_o(cfg_err_o), .cfg_timeout_o(cfg_timeout_o),
    .tx_busy_i(tx_busy_i), .rx_busy_i(rx_busy_i), .hold_o(hold_o),
    .baud_clk_i(baud_clk_i), .baud_modulo_o(baud_modulo_o),
    .baud_rst_n_o(baud_rst_n_o), .baud_tick_o(baud_tick_o)
  );

  // Generator model: half period M+1 cycles; its count includes the release
  // cycle, so the first rising edge lands M cycles after release.
  logic [W-1:0] g_cnt = 32'd1;
  always @(posedge clk_i) begin
    if (baud_rst_n_o !== 1'b1) begin
      g_cnt      <= 32'd1;
      baud_clk_i <= 1'b0;
    end else if (g_cnt >= baud_modulo_o) begin
      g_cnt      <= '0;
      baud_clk_i <= ~baud_clk_i;
    end else begin
      g_cnt <= g_cnt + 32'd1;
    end
  end

  // Reference model: 0 = running, 1 = draining, 2 = loading.
  int           ph;
  logic [W-1:0] cur, pend;
  longint       cycn, rel;
  int           dcnt;
  logic         e_err, e_tout;
  int           n_vec = 0, n_miss = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cycn);
    end
  endtask

  function automatic logic exp_tick();
    longint m, d;
    if (ph != 0) return 1'b0;
    m = longint'(cur);
    d = cycn - rel - (m + 1);
    if (d < 0) return 1'b0;
    return (d % (2 * m + 2)) == 0;
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [W-1:0] m,
                            input logic tb, input logic rb);
    e_err  = 1'b0;
    e_tout = 1'b0;
    if (r) begin
      ph = 2; cur = DEF; pend = DEF;
    end else begin
      case (ph)
        0: if (v) begin
             if (m < MINM) e_err = 1'b1;
             else if (m != cur) begin pend = m; ph = 1; dcnt = 0; end
           end
        1: if (!tb && !rb) begin
             ph = 2; cur = pend;
           end else begin
`ifdef BAUD_DRAIN_TIMEOUT_EN
             if (dcnt + 1 == TOUT) begin ph = 2; cur = pend; e_tout = 1'b1; end
             else dcnt++;
`endif
           end
        default: begin ph = 0; rel = cycn + 1; end
      endcase
    end
    cycn++;
  endtask

  task automatic cyc(input logic r, input logic v, input logic [W-1:0] m,
                     input logic tb, input logic rb);
    rst_i = r; cfg_valid_i = v; cfg_modulo_i = m; tx_busy_i = tb; rx_busy_i = rb;
    @(posedge clk_i);
    model_step(r, v, m, tb, rb);
    @(negedge clk_i);
    chk("cfg_ready_o",   cfg_ready_o,   ph == 0);
    chk("hold_o",        hold_o,        ph != 0);
    chk("baud_rst_n_o",  baud_rst_n_o,  ph != 2);
    chk("cfg_err_o",     cfg_err_o,     e_err);
    chk("cfg_timeout_o", cfg_timeout_o, e_tout);
    chk("baud_modulo_o", baud_modulo_o, cur);
    chk("baud_tick_o",   baud_tick_o,   exp_tick());
  endtask

  typedef struct {
    logic v; logic [W-1:0] m; logic tb; logic rb;
    logic rdy; logic hold; logic rstn; logic err; logic [W-1:0] mod;
  } vec_t;

  vec_t tv[18];
  int   k, nt, nh;

  initial begin
    // Expected outputs are those of the cycle after the row's inputs are applied.
    tv[0]  = '{1'b1, 32'd10,         1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd216};
    tv[1]  = '{1'b0, 32'd0,          1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd10};
    tv[2]  = '{1'b0, 32'd0,          1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd10};
    tv[3]  = '{1'b1, 32'd3,          1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd10};
    tv[4]  = '{1'b0, 32'd0,          1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd10};
    tv[5]  = '{1'b1, 32'd10,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd10};
    tv[6]  = '{1'b1, 32'd0,          1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd10};
    tv[7]  = '{1'b1, 32'h8000_0003,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd10};
    tv[8]  = '{1'b1, 32'd5,          1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd10};
    tv[9]  = '{1'b0, 32'd0,          1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd10};
    tv[10] = '{1'b1, 32'd3,          1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0003};
    tv[11] = '{1'b1, 32'd3,          1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0003};
    tv[12] = '{1'b1, 32'd4,          1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_0003};
    tv[13] = '{1'b0, 32'd0,          1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4};
    tv[14] = '{1'b0, 32'd0,          1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd4};
    tv[15] = '{1'b1, 32'd10,         1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd4};
    tv[16] = '{1'b0, 32'd0,          1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd10};
    tv[17] = '{1'b0, 32'd0,          1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd10};

    ph = 2; cur = DEF; pend = DEF; cycn = 0; rel = 0; dcnt = 0; e_err = 0; e_tout = 0;

    // Reset and release: one LOAD cycle, then first tick M+1 cycles into RUN.
    repeat (3) cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("released_rst_n", baud_rst_n_o, 1'b1);
    k = 0;
    while (!baud_tick_o && k < 600) begin cyc(1'b0, 1'b0, '0, 1'b0, 1'b0); k++; end
    chk("first_tick_216", k, 217);
    k = 0;
    do begin cyc(1'b0, 1'b0, '0, 1'b0, 1'b0); k++; end while (!baud_tick_o && k < 1000);
    chk("tick_period_216", k, 434);

    // Table: request/err/equal/ignored-in-drain/width/min sequences.
    for (int i = 0; i < 18; i++) begin
      cyc(1'b0, tv[i].v, tv[i].m, tv[i].tb, tv[i].rb);
      chk($sformatf("row%0d ready", i), cfg_ready_o,   tv[i].rdy);
      chk($sformatf("row%0d hold", i),  hold_o,        tv[i].hold);
      chk($sformatf("row%0d rstn", i),  baud_rst_n_o,  tv[i].rstn);
      chk($sformatf("row%0d err", i),   cfg_err_o,     tv[i].err);
      chk($sformatf("row%0d mod", i),   baud_modulo_o, tv[i].mod);
    end

    // M=10: first tick 11 cycles after release, then every 22.
    k = 0;
    while (!baud_tick_o && k < 100) begin cyc(1'b0, 1'b0, '0, 1'b0, 1'b0); k++; end
    chk("first_tick_10", k, 11);
    for (int p = 0; p < 2; p++) begin
      k = 0;
      do begin cyc(1'b0, 1'b0, '0, 1'b0, 1'b0); k++; end while (!baud_tick_o && k < 100);
      chk("tick_period_10", k, 22);
    end

    // Request 50 while TX busy for 100 cycles.
    cyc(1'b0, 1'b1, 32'd50, 1'b1, 1'b0);
    nt = 0; nh = 0;
    for (int i = 0; i < 99; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
      if (baud_tick_o) nt++;
      if (hold_o && baud_rst_n_o) nh++;
    end
    chk("drain_hold_cycles", nh, 99);
    chk("drain_ticks", nt, 0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("load_after_tx_idle", baud_rst_n_o, 1'b0);
    chk("load_mod_50", baud_modulo_o, 32'd50);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("run_after_load", hold_o, 1'b0);

    // Reset during DRAIN discards the pending modulo.
    cyc(1'b0, 1'b1, 32'd77, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("mod_after_drain_rst", baud_modulo_o, DEF);

    // RX stuck busy.
    cyc(1'b0, 1'b1, 32'd30, 1'b0, 1'b1);
`ifdef BAUD_DRAIN_TIMEOUT_EN
    nh = 0;
    for (int i = 0; i < 1000; i++) begin
      if (cfg_timeout_o) break;
      if (hold_o && baud_rst_n_o) nh++;
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    end
    chk("timeout_drain_cycles", nh, TOUT);
    chk("timeout_pulse", cfg_timeout_o, 1'b1);
    chk("timeout_load", baud_rst_n_o, 1'b0);
    chk("timeout_mod", baud_modulo_o, 32'd30);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
`else
    nh = 0;
    for (int i = 0; i < 1000; i++) begin
      if (hold_o && baud_rst_n_o) nh++;
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    end
    chk("stuck_drain_cycles", nh, 1000);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("stuck_release_load", baud_rst_n_o, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      logic         rr, vv, tb, rb;
      logic [W-1:0] mm;
      rr = ($urandom_range(599) == 0);
      vv = ($urandom_range(5) == 0);
      mm = ($urandom_range(3) == 0) ? cur : W'($urandom_range(14));
      tb = ($urandom_range(2) == 0);
      rb = ($urandom_range(2) == 0);
      cyc(rr, vv, mm, tb, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/baud_ctrl.md
Name: baud_ctrl

Overview:
- Configuration sequencer for the UART baud generator (clk_i domain).
- Accepts divisor updates over a valid/ready handshake and stalls TX/RX at frame boundaries.
- Applies the new modulo under a one-cycle generator reset.
- Converts the generator's toggling baud_clk into a one-cycle baud_tick_o enable for the TX/RX engines.

Parameters:
- BAUD_WIDTH, 32: width of the modulo path.
- DEFAULT_MODULO, 216: modulo loaded at reset. Baud period = 2*(M+1) clk_i cycles.
- MIN_MODULO, 4: smallest legal modulo. Smaller requests are rejected.
- DRAIN_TIMEOUT, 65535: drain cycles before a forced load. Used only with the optional feature.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- cfg_modulo_i  in  BAUD_WIDTH  requested modulo
- cfg_valid_i  in  1  request valid
- cfg_ready_o  out  1  controller can accept a request
- cfg_err_o  out  1  one-cycle pulse: request rejected
- cfg_timeout_o  out  1  one-cycle pulse: drain timed out
- tx_busy_i  in  1  TX mid-frame
- rx_busy_i  in  1  RX mid-frame
- hold_o  out  1  TX/RX must not start a new frame
- baud_clk_i  in  1  toggling output of the baud generator
- baud_modulo_o  out  BAUD_WIDTH  modulo driven to the generator
- baud_rst_n_o  out  1  generator reset, active-low, registered
- baud_tick_o  out  1  one-cycle pulse per baud_clk_i rising edge

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk_i, rst_i).
- All outputs are registered.
- Reset values:
  - state=LOAD, baud_modulo_o=DEFAULT_MODULO, baud_rst_n_o=0, hold_o=1
  - cfg_ready_o=0, cfg_err_o=0, cfg_timeout_o=0, baud_tick_o=0
  - pending=DEFAULT_MODULO, edge register=0
- States:
  - RUN: baud_rst_n_o=1, hold_o=0, cfg_ready_o=1.
    - Handshake occurs on cfg_valid_i & cfg_ready_o.
    - If cfg_modulo_i < MIN_MODULO: cfg_err_o=1 next cycle; stay RUN; modulo unchanged.
    - If cfg_modulo_i == baud_modulo_o: accept silently; stay RUN; no generator reset.
    - Otherwise: pending<=cfg_modulo_i; next cycle hold_o=1, cfg_ready_o=0, go DRAIN.
  - DRAIN: hold_o=1, cfg_ready_o=0.
    - When tx_busy_i==0 and rx_busy_i==0 in the same cycle, go LOAD.
    - If both are already idle on entry, DRAIN lasts exactly 1 cycle.
  - LOAD, exactly 1 cycle: baud_rst_n_o=0, baud_modulo_o<=pending, edge register<=0, hold_o=1. Next state RUN.
- Latency: accepting handshake to baud_rst_n_o low is 2 cycles minimum (1 in DRAIN plus entry); returns to RUN on the following cycle.
- Tick generation:
  - baud_tick_o=1 in the cycle after baud_clk_i is sampled 1 with the previous sample 0, and only while state==RUN.
  - Suppressed in DRAIN and LOAD; sampling continues in DRAIN.
  - The first tick after LOAD occurs M+1 cycles after release, which is the generator's first toggle.
- cfg_valid_i outside RUN is ignored; it is not queued.
- rst_i mid-DRAIN/LOAD:
  - The pending request is discarded.
  - The controller restarts in LOAD with DEFAULT_MODULO.
- Width rule: comparisons are unsigned on full BAUD_WIDTH, with no truncation.

Optional Feature:
- Macro: BAUD_DRAIN_TIMEOUT_EN.
- Defined:
  - A BAUD_WIDTH-bit counter clears on DRAIN entry and increments each DRAIN cycle.
  - At count == DRAIN_TIMEOUT, the controller forces LOAD and pulses cfg_timeout_o for 1 cycle, regardless of the busy inputs.
  - A busy-free exit before the limit produces no pulse.
- Undefined:
  - DRAIN waits indefinitely.
  - cfg_timeout_o is tied 0 and the counter is absent.

Decomposition:
- Shared defs header holds:
  - state encodings (RUN, DRAIN, LOAD)
  - BAUD_WIDTH
  - DEFAULT_MODULO for standard rates (9600, 19200, 115200 at 50 MHz)
- One sub-module: baud_edge_det.
  - Registered rising-edge detector with synchronous clear and enable.
  - Produces baud_tick_o.

Test Plan:
- Reset release:
  - baud_rst_n_o=0 for exactly 1 cycle after rst_i falls.
  - baud_modulo_o=216.
  - First baud_tick_o 217 cycles after release; subsequent ticks every 434 cycles.
- Request modulo=10 with TX/RX idle:
  - cfg_ready_o drops.
  - hold_o=1 for 2 cycles; baud_rst_n_o low 1 cycle; baud_modulo_o=10.
  - Ticks every 22 cycles thereafter.
- Request modulo=50 while tx_busy_i=1 for 100 cycles:
  - Stays in DRAIN with hold_o=1 and no ticks.
  - LOAD occurs the cycle after tx_busy_i falls.
- Request modulo=3 (below MIN_MODULO):
  - cfg_err_o pulses once; baud_modulo_o unchanged; no reset.
  - Request equal to the current modulo: accepted, no cfg_err_o, no baud_rst_n_o pulse.
- rst_i asserted in DRAIN:
  - After release, baud_modulo_o=216; the pending value is lost.
- With BAUD_DRAIN_TIMEOUT_EN and DRAIN_TIMEOUT=20, with rx_busy_i stuck at 1:
  - cfg_timeout_o pulses after 20 DRAIN cycles, then LOAD.
  - Without the macro, the controller stays in DRAIN for 1000 cycles.
